// File: rtl/eth_mgmt_arbiter_if.sv
// -----------------------------------------------------------------------------
// eth_mgmt_arbiter_if
//   Bundles the two requester command channels, the completion channel and the
//   management-port signals of eth_mgmt_arbiter.
//
//   slave  : arbiter side (consumes requests, drives responses and mgmt port)
//   master : requester / environment side (drives requests and mgmt_rd_data)
//
//   Signals
//     reqN_valid  command pending on requester N
//     reqN_ready  requester N's command accepted this cycle
//     reqN_rd     1 = read, 0 = write
//     reqN_addr   16-bit management register address
//     reqN_wdata  32-bit write data
//     rsp_valid   single-cycle completion pulse
//     rsp_id      requester that owns the completing command
//     rsp_rdata   read data (0 for writes), held until the next completion
//     mgmt_ctrl_addr  {14'b0, rd_strobe, wr_strobe, addr}
//     mgmt_wr_data    write data towards the management port
//     mgmt_rd_data    read data from the management port, already in clk
//     busy        arbiter is handling a command
// -----------------------------------------------------------------------------
interface eth_mgmt_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic        req0_rd;
  logic [15:0] req0_addr;
  logic [31:0] req0_wdata;

  logic        req1_valid;
  logic        req1_ready;
  logic        req1_rd;
  logic [15:0] req1_addr;
  logic [31:0] req1_wdata;

  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_rdata;

  logic [31:0] mgmt_ctrl_addr;
  logic [31:0] mgmt_wr_data;
  logic [31:0] mgmt_rd_data;

  logic        busy;

  modport slave (
    input  req0_valid, req0_rd, req0_addr, req0_wdata,
    input  req1_valid, req1_rd, req1_addr, req1_wdata,
    input  mgmt_rd_data,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_rdata,
    output mgmt_ctrl_addr, mgmt_wr_data,
    output busy
  );

  modport master (
    output req0_valid, req0_rd, req0_addr, req0_wdata,
    output req1_valid, req1_rd, req1_addr, req1_wdata,
    output mgmt_rd_data,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_rdata,
    input  mgmt_ctrl_addr, mgmt_wr_data,
    input  busy
  );
endinterface

// File: rtl/eth_mgmt_arbiter.sv
// -----------------------------------------------------------------------------
// eth_mgmt_arbiter
//   Arbitrates two requesters onto a slow management port that lives in a
//   different clock domain. Each command is presented by holding the read or
//   write strobe for HOLD_CYCLES so the far side can sample it, then clearing
//   the strobes for SETTLE_CYCLES before read data (already synchronised into
//   clk) is captured and a one-cycle completion is returned.
//
//   Parameters
//     HOLD_CYCLES   strobe assertion length in cycles (1..255)
//     SETTLE_CYCLES strobe-low settle time before capture (1..255)
//
//   Ports
//     clk    single clock
//     rst_n  asynchronous active-low reset
//     bus    eth_mgmt_arbiter_if.slave: requester channels, completion channel,
//            management port and busy flag
//
//   Timing for a command accepted at cycle T:
//     ISSUE    T+1 .. T+HOLD
//     RELEASE  T+HOLD+1 .. T+HOLD+SETTLE
//     CAPTURE  T+HOLD+SETTLE+1 (rsp_valid high)
//     IDLE     from T+HOLD+SETTLE+2, earliest next acceptance
// -----------------------------------------------------------------------------
module eth_mgmt_arbiter #(
  parameter int HOLD_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  eth_mgmt_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Counter reload values; the state advances when the counter reads 0, so a
  // reload of N-1 gives a phase exactly N cycles long.
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        last_grant;
  logic        cmd_rd;
  logic        cmd_id;
  logic [31:0] rdata_q;

  logic        grant_vld;
  logic        grant_id;
  logic        sel_rd;
  logic [15:0] sel_addr;
  logic [31:0] sel_wdata;

  // Combinational grant, only meaningful in IDLE. On a tie the requester that
  // was not served last wins; last_grant resets to 1 so req0 wins first.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant;
      end else if (bus.req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant_vld & ~grant_id;
  assign bus.req1_ready = grant_vld &  grant_id;

  assign sel_rd    = grant_id ? bus.req1_rd    : bus.req0_rd;
  assign sel_addr  = grant_id ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = grant_id ? bus.req1_wdata : bus.req0_wdata;

  // Command sequencer. The mgmt_ctrl_addr / mgmt_wr_data registers double as
  // the latched address and write data of the command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= 8'd0;
      last_grant         <= 1'b1;
      cmd_rd             <= 1'b0;
      cmd_id             <= 1'b0;
      rdata_q            <= 32'd0;
      bus.mgmt_ctrl_addr <= 32'd0;
      bus.mgmt_wr_data   <= 32'd0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_id         <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            state              <= ISSUE;
            cnt                <= HOLD_LD;
            last_grant         <= grant_id;
            cmd_rd             <= sel_rd;
            cmd_id             <= grant_id;
            bus.mgmt_ctrl_addr <= {14'b0, sel_rd, ~sel_rd, sel_addr};
            bus.mgmt_wr_data   <= sel_rd ? 32'd0 : sel_wdata;
          end
        end
        ISSUE: begin
          if (cnt == 8'd0) begin
            state                     <= RELEASE;
            cnt                       <= SETTLE_LD;
            bus.mgmt_ctrl_addr[17:16] <= 2'b00;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RELEASE: begin
          if (cnt == 8'd0) begin
            state         <= CAPTURE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= cmd_id;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CAPTURE: begin
          state              <= IDLE;
          bus.mgmt_ctrl_addr <= 32'd0;
          rdata_q            <= cmd_rd ? bus.mgmt_rd_data : 32'd0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // During CAPTURE the response carries the read data present in that same
  // cycle; the registered copy taken at the end of CAPTURE holds it afterwards.
  assign bus.rsp_rdata = (state == CAPTURE) ? (cmd_rd ? bus.mgmt_rd_data : 32'd0)
                                            : rdata_q;

  assign bus.busy = (state != IDLE);

endmodule

// File: doc/eth_mgmt_arbiter.md
ETH_MGMT_ARBITER -- requirements
Module: eth_mgmt_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 8: cycles the command bits stay asserted so the request crosses into the management clock domain.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16: cycles with command bits cleared before read data is sampled; legal range for both parameters is 1..255.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each: requester N has a command pending.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1 each: requester N's command is accepted this cycle.
REQ-007 SHALL have ports req0_rd / req1_rd, input, 1 each: 1 = read, 0 = write.
REQ-008 SHALL have ports req0_addr / req1_addr, input, 16 each: management register address.
REQ-009 SHALL have ports req0_wdata / req1_wdata, input, 32 each: write data.
REQ-010 SHALL have port rsp_valid, output, 1: single-cycle completion pulse.
REQ-011 SHALL have port rsp_id, output, 1: requester that owns the completing command.
REQ-012 SHALL have port rsp_rdata, output, 32: read data; 0 for writes.
REQ-013 SHALL have port mgmt_ctrl_addr, output, 32: bit 17 = read strobe, bit 16 = write strobe, bits 15:0 = address, bits 31:18 = 0.
REQ-014 SHALL have port mgmt_wr_data, output, 32: write data to the management port.
REQ-015 SHALL have port mgmt_rd_data, input, 32: read data, already synchronized into clk.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, RELEASE and CAPTURE.
REQ-018 IDLE: grant SHALL be combinational.
- Only one valid: that requester is granted.
- Both valid: the requester not served last is granted.
- last_grant resets to 1, so req0 wins the first tie.
REQ-019 reqN_ready SHALL be 1 only in IDLE and only for the granted requester; it SHALL never be high for both requesters in the same cycle.
REQ-020 On acceptance (valid & ready at cycle T), the block SHALL latch rd, addr, wdata and id, update last_grant, and be in ISSUE from T+1.
REQ-021 ISSUE SHALL last exactly HOLD_CYCLES cycles.
- mgmt_ctrl_addr = {14'b0, rd, ~rd, addr}.
- mgmt_wr_data = wdata for writes, 0 for reads.
REQ-022 RELEASE SHALL last exactly SETTLE_CYCLES cycles.
- mgmt_ctrl_addr[17:16] = 0; address bits held.
- mgmt_wr_data held.
REQ-023 CAPTURE SHALL last one cycle.
- Cycle index: T+HOLD_CYCLES+SETTLE_CYCLES+1.
- rsp_valid = 1, rsp_id = latched id.
- rsp_rdata = mgmt_rd_data sampled that cycle for reads, 0 for writes.
- Next state is IDLE.
REQ-024 rsp_rdata SHALL hold its value until the next CAPTURE; rsp_valid SHALL be 0 outside CAPTURE.
REQ-025 A requester dropping valid before ready SHALL be legal; no state changes.
REQ-026 Request inputs SHALL be ignored outside IDLE; a new command can be accepted no earlier than the cycle after CAPTURE, so back-to-back commands have a period of HOLD_CYCLES+SETTLE_CYCLES+2 cycles.
REQ-027 The down-counter SHALL be 8 bits, loaded with PARAM-1 on state entry, and the state SHALL advance when the counter reads 0; no wrap-around is permitted.
REQ-028 mgmt_ctrl_addr SHALL be 0 in IDLE, so exactly one strobe edge is produced per command.

Reset
REQ-029 rst_n low SHALL immediately force the following, regardless of state:
- state = IDLE, counter = 0, last_grant = 1;
- mgmt_ctrl_addr = 0, mgmt_wr_data = 0;
- rsp_valid = 0, rsp_id = 0, rsp_rdata = 0, busy = 0.
REQ-030 A command in flight during reset SHALL be discarded with no rsp_valid; after release, operation SHALL restart from IDLE on the first clk edge.

Verification
REQ-031 Single write with HOLD=8, SETTLE=16: req0 write addr 0x0010, wdata 0xDEADBEEF.
- ISSUE: mgmt_ctrl_addr = 0x00010010 for 8 cycles.
- RELEASE: 0x00000010 for 16 cycles.
- rsp_valid at T+25 with rsp_id=0, rsp_rdata=0.
REQ-032 Single read: req1 read addr 0x0042, mgmt_rd_data = 0x12345678.
- ISSUE: mgmt_ctrl_addr = 0x00020042.
- At T+25: rsp_valid=1, rsp_id=1, rsp_rdata=0x12345678.
REQ-033 Contention: both valid continuously from reset.
- Grants alternate 0,1,0,1.
- Accept spacing is exactly 26 cycles.
- reqN_ready is never high for both requesters at once.
REQ-034 Reset mid-ISSUE: assert rst_n=0 at cycle T+3.
- mgmt_ctrl_addr = 0 asynchronously.
- No rsp_valid occurs.
- After release, the first command completes normally.
REQ-035 Withdrawn request: req0_valid pulses for one cycle while busy.
- No acceptance, no strobe, no response.
REQ-036 Parameter corner HOLD=1, SETTLE=1: read completes with rsp_valid at T+3 and a 4-cycle back-to-back period.
